// File: rtl/gray_seq_pkg.sv
// Shared types and helpers for the gray-code sequence monitor and other gray consumers.
package gray_seq_pkg;

  localparam int DEF_WIDTH = 3;
  localparam int MAXCODE   = (1 << DEF_WIDTH) - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_e;

  // Generic 32-bit decode; zero-extended narrower codes decode correctly.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    logic        acc;
    b   = 32'd0;
    acc = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_seq_monitor_if.sv
// Sample bus between a gray counter (master) and the sequence monitor (slave).
interface gray_seq_monitor_if #(
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 8
);
  logic              Valid;
  logic [WIDTH-1:0]  GrayIn;
  logic              Clear;
  logic [WIDTH-1:0]  BinOut;
  logic              BinValid;
  logic              Locked;
  logic              Wrap;
  logic [WRAP_W-1:0] WrapCount;
  logic              Error;

  modport master (
    output Valid, GrayIn, Clear,
    input  BinOut, BinValid, Locked, Wrap, WrapCount, Error
  );

  modport slave (
    input  Valid, GrayIn, Clear,
    output BinOut, BinValid, Locked, Wrap, WrapCount, Error
  );
endinterface

// File: rtl/gray2bin_comb.sv
// Purely combinational gray-to-binary decoder, reusable by any gray consumer.
module gray2bin_comb #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Each binary bit is the XOR of all gray bits at and above its position.
  always_comb begin
    logic acc;
    acc   = 1'b0;
    bin_o = {WIDTH{1'b0}};
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc      = acc ^ gray_i[i];
      bin_o[i] = acc;
    end
  end

endmodule

// File: rtl/gray_seq_monitor.sv
// Decodes a gray sample stream, checks single-step progression, counts wraps
// and latches a sticky error on any illegal step.
module gray_seq_monitor
  import gray_seq_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  gray_seq_monitor_if.slave   bus
);

  localparam logic [WIDTH-1:0]  MAX_CODE  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]  STEP_ONE  = WIDTH'(1'b1);
  localparam logic [WIDTH-1:0]  ZERO_CODE = {WIDTH{1'b0}};
  localparam logic [WRAP_W-1:0] WRAP_MAX  = {WRAP_W{1'b1}};
  localparam logic [WRAP_W-1:0] WRAP_ONE  = WRAP_W'(1'b1);

  logic [WIDTH-1:0]  bin_s;
  logic [WIDTH-1:0]  delta_s;

  state_e            state_q,     state_d;
  logic [WIDTH-1:0]  prev_q,      prev_d;
  logic [WIDTH-1:0]  bin_q,       bin_d;
  logic              bin_valid_q, bin_valid_d;
  logic              locked_q,    locked_d;
  logic              wrap_q,      wrap_d;
  logic [WRAP_W-1:0] wrap_cnt_q,  wrap_cnt_d;
  logic              error_q,     error_d;

  gray2bin_comb #(.WIDTH(WIDTH)) u_dec (
    .gray_i (bus.GrayIn),
    .bin_o  (bin_s)
  );

  assign delta_s = bin_s - prev_q;

  // Next-state logic: decode path, clear priority, then the tracking FSM.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    locked_d    = locked_q;
    wrap_d      = 1'b0;
    wrap_cnt_d  = wrap_cnt_q;
    error_d     = error_q;
    bin_valid_d = bus.Valid;

    if (bus.Valid) begin
      bin_d = bin_s;
    end else begin
      bin_d = bin_q;
    end

    if (bus.Clear) begin
      state_d  = IDLE;
      error_d  = 1'b0;
      locked_d = 1'b0;
    end else if (bus.Valid) begin
      case (state_q)
        IDLE: begin
          prev_d   = bin_s;
          locked_d = 1'b1;
          state_d  = TRACK;
        end
        TRACK: begin
          if (delta_s == ZERO_CODE) begin
            prev_d = prev_q;
          end else if (delta_s == STEP_ONE) begin
            prev_d = bin_s;
            if (prev_q == MAX_CODE) begin
              wrap_d = 1'b1;
              if (wrap_cnt_q != WRAP_MAX) begin
                wrap_cnt_d = wrap_cnt_q + WRAP_ONE;
              end else begin
                wrap_cnt_d = wrap_cnt_q;
              end
            end else begin
              wrap_d = 1'b0;
            end
          end else begin
            // prev deliberately keeps the last legal code for debug visibility
            error_d  = 1'b1;
            locked_d = 1'b0;
            state_d  = FAULT;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d  = IDLE;
          locked_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      prev_q      <= ZERO_CODE;
      bin_q       <= ZERO_CODE;
      bin_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      wrap_q      <= 1'b0;
      wrap_cnt_q  <= {WRAP_W{1'b0}};
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      bin_q       <= bin_d;
      bin_valid_q <= bin_valid_d;
      locked_q    <= locked_d;
      wrap_q      <= wrap_d;
      wrap_cnt_q  <= wrap_cnt_d;
      error_q     <= error_d;
    end
  end

  assign bus.BinOut    = bin_q;
  assign bus.BinValid  = bin_valid_q;
  assign bus.Locked    = locked_q;
  assign bus.Wrap      = wrap_q;
  assign bus.WrapCount = wrap_cnt_q;
  assign bus.Error     = error_q;

endmodule

// File: doc/gray_seq_monitor.md
Name: gray_seq_monitor

Overview:
Receiving end of the gray-counter output bus. Decodes a WIDTH-bit gray-coded sample stream to binary and registers the result. Checks that successive valid samples advance by exactly one code step, counts wrap-arounds and flags sequence violations. Sits downstream of the gray counter as its checker and decoder.

Parameters:
WIDTH, 3, gray/binary code width.
WRAP_W, 8, width of the wrap counter.

Ports:
Clk  input  1  clock; all state updates on the rising edge.
Reset  input  1  synchronous, active-high reset.
Valid  input  1  GrayIn carries a sample this cycle.
GrayIn  input  WIDTH  gray-coded sample.
Clear  input  1  synchronous clear of tracking state and Error; does not clear WrapCount.
BinOut  output  WIDTH  registered binary decode of the last valid sample.
BinValid  output  1  1-cycle pulse, aligned with a BinOut update.
Locked  output  1  monitor is tracking a legal sequence.
Wrap  output  1  1-cycle pulse on a max-to-0 step.
WrapCount  output  WRAP_W  number of wraps; saturates at all-ones.
Error  output  1  sticky sequence-violation flag.

Behaviour:
- Reset (synchronous, active-high, clock Clk): all outputs go to 0 and the internal register prev goes to 0. The FSM goes to IDLE. Reset overrides all other inputs.
- Decode: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] ^ g[i]. The path is combinational into registers, so latency is 1 cycle.
- When Valid=1: BinOut <= bin and BinValid <= 1. Otherwise BinValid <= 0 and BinOut holds. This applies in every FSM state, including when Clear=1.
- delta = (bin - prev) mod 2^WIDTH, computed at WIDTH bits.
- FSM states: IDLE, TRACK, FAULT.
  - IDLE: on Valid, prev <= bin, Locked <= 1, go to TRACK. No error check on this first sample.
  - TRACK, on Valid:
    - delta==0: legal repeat; no change.
    - delta==1: prev <= bin. If prev==2^WIDTH-1 (so bin==0), pulse Wrap and increment WrapCount, saturating at 2^WRAP_W-1. Wrap still pulses while saturated.
    - any other delta: Error <= 1, Locked <= 0, go to FAULT. prev is not updated.
  - FAULT: sequence tracking stops. Error and Locked=0 hold. Decode continues.
- Clear=1, outside Reset: go to IDLE; Error <= 0, Locked <= 0, Wrap <= 0. The same-cycle sample is decoded but not tracked. Clear has priority over the FSM in every state.
- Valid=0 cycles: no state change; Wrap <= 0.
- Reset mid-sequence: the next edge returns the block to its reset values. The first following sample re-locks without an error.

Decomposition:
- Package gray_seq_pkg:
  - state enum {IDLE, TRACK, FAULT};
  - constant MAXCODE = 2^WIDTH-1;
  - gray2bin function.
- One natural sub-module, gray2bin_comb: parameterised WIDTH, purely combinational decode. It is reusable by other gray consumers.
- The FSM, counter and registers stay in the top module.

Test Plan:
- Reset, then Valid with GrayIn = 0,1,3,2,6,7,5,4,0 -> BinOut = 0,1,2,3,4,5,6,7,0, each 1 cycle after its sample. Locked=1 from the 2nd cycle. Wrap pulses once, on the final sample. WrapCount=1. Error=0.
- GrayIn = 0,1,1,3 with gaps where Valid=0 -> the repeat is legal. BinOut ends at 2, Error=0, BinValid pulses exactly 4 times.
- GrayIn = 0,1,2 (binary 0,1,3) -> after the 3rd sample, Error=1, Locked=0, BinOut=3. Further legal samples keep Error=1.
- From FAULT, assert Clear together with GrayIn=6 -> next cycle Error=0, Locked=0, BinOut=4. Then GrayIn=7 gives Locked=1 with no error.
- With WRAP_W=2, run 5 full cycles -> WrapCount goes 1,2,3,3,3 and Wrap pulses 5 times.
- Assert Reset mid-sequence while BinOut=5 and WrapCount=2 -> next edge all outputs = 0. The next sample, GrayIn=5, re-locks with Error=0.
